midi_note_parser: RTL and testbench
===================================

# midi_note_parser

Byte-level MIDI parser that turns the serial MIDI stream (bytes from the UART receiver) into the monophonic note controls consumed by `midi_player`: a held note number, a note-held level, and a velocity-derived amplitude. It implements running status, channel filtering, velocity-0 note-off and last-note priority. It sits directly upstream of `midi_player`; its `midi_data`, `midi_valid` and `amplitude` outputs connect to that block's inputs of the same names.

## Interface
- `CHANNEL`, 0: MIDI channel (0–15) accepted when `OMNI`=0.
- `OMNI`, 0: 1 = accept note messages on all channels.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  received MIDI byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid on this cycle.
- `midi_data`  out  8  current note number, bit 7 always 0.
- `midi_valid`  out  1  level; high while the note is held.
- `amplitude`  out  8  velocity scaled to 8 bits.
- `note_event`  out  1  one-cycle pulse on any change of `midi_data`, `midi_valid` or `amplitude`.
- `parse_err`  out  1  one-cycle pulse when a data byte is dropped because there is no running status.

## Operation
Byte classes:
- Data: bit 7 = 0.
- Channel status: 0x80–0xEF. Stores status and channel as running status, then goes to WAIT_D1.
- System common: 0xF0–0xF7. Clears running status, goes to IDLE, no other effect.
- Real-time: 0xF8–0xFE. Fully ignored; state, running status and any partial data byte are untouched.
- 0xFF (System Reset): goes to IDLE, clears running status, drives `midi_valid` to 0. `midi_data` and `amplitude` are retained.

Parser states:
- IDLE: data byte → `parse_err` pulse, byte dropped.
- WAIT_D1: data byte → latch d1.
  - Status 0xC0/0xD0 (one data byte): message complete, stay in WAIT_D1.
  - Otherwise: go to WAIT_D2.
- WAIT_D2: data byte → message complete, return to WAIT_D1 (running status).
- A status byte arriving in any state aborts the partial message. The new status applies.

Completed messages act only on 0x8n/0x9n where n = `CHANNEL`, or any n when `OMNI`=1. All other completed messages are discarded silently.
- Note-on with velocity v > 0: `midi_data`←d1, `midi_valid`←1, `amplitude`←{v[6:0], v[6]}. Last-note priority: this always replaces the current note, including re-strike of the same note.
- Note-off, or note-on with v = 0: if `midi_valid`=1 and d1 == `midi_data`, then `midi_valid`←0. Otherwise ignored. `midi_data` and `amplitude` hold their last values.
- `note_event` pulses only when an output value actually changes. A re-strike with the same note and same velocity gives no pulse.

## Timing
- Reset values: `midi_data`=0, `midi_valid`=0, `amplitude`=0, `note_event`=0, `parse_err`=0. State = IDLE, running status cleared.
- Latency: outputs update on the clock edge after the `rx_valid` cycle that carries the completing byte. `note_event` and `parse_err` are high for exactly that one cycle.
- `rx_valid` may be asserted on consecutive cycles; each byte is processed with no stall.
- Outputs are registered and hold steady between events.
- `rst` in the middle of a message discards the partial message. The first data byte after reset gives `parse_err`.
- `rst` has priority over a simultaneous `rx_valid`.

## Test plan
- Reset, then send 0x90 0x3C 0x7F → one cycle after the last byte: `midi_data`=60, `midi_valid`=1, `amplitude`=0xFF, `note_event` pulse. Then send 0x3C 0x00 (running status) → `midi_valid`=0, `midi_data` stays 60.
- Send 0x90 0x3C 0x40, then 0x3E 0x01 → note 62 replaces 60 with `amplitude`=0x02. Then send 0x80 0x3C 0x10 → no change, because 60 is not current. Then 0x3E 0x10 → `midi_valid`=0.
- Send 0x90 0xF8 0x3C 0xFE 0x7F (real-time bytes interleaved) → same result as 0x90 0x3C 0x7F.
- After reset, send 0x3C → `parse_err` pulse, outputs unchanged. Send 0xC0 0x05 0x3C → no note change, stays in WAIT_D1. Send 0x91 0x3C 0x7F with `CHANNEL`=0 and `OMNI`=0 → ignored.
- Send 0x90 0x3C, then assert `rst`, then send 0x7F → `parse_err` pulse, `midi_valid`=0. While a note is held, send 0xFF → `midi_valid`=0, `midi_data` retained.

Source files
------------

// File: rtl/midi_note_parser.sv
// Byte-level MIDI parser: running status, channel filter and last-note priority,
// reduced to one held note with a velocity-derived amplitude for midi_player.
module midi_note_parser #(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] amplitude,
  output logic       note_event,
  output logic       parse_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_e;

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  state_e     state_q, state_d;
  logic [3:0] status_q, status_d;
  logic [3:0] chan_q, chan_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic       held_q, held_d;
  logic [7:0] amp_q, amp_d;
  logic       event_q, event_d;
  logic       err_q, err_d;

  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       chan_ok;

  assign chan_ok = OMNI || (chan_q == CHAN);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    chan_d   = chan_q;
    d1_d     = d1_q;
    note_d   = note_q;
    held_d   = held_q;
    amp_d    = amp_q;
    err_d    = 1'b0;
    msg_done = 1'b0;
    msg_d1   = d1_q;
    msg_d2   = 7'd0;

    if (rx_valid) begin
      if (!rx_byte[7]) begin
        unique case (state_q)
          IDLE: err_d = 1'b1;
          WAIT_D1: begin
            d1_d = rx_byte[6:0];
            // Program change and channel pressure carry a single data byte.
            if (status_q == 4'hC || status_q == 4'hD) begin
              msg_done = 1'b1;
              msg_d1   = rx_byte[6:0];
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            msg_d2   = rx_byte[6:0];
            state_d  = WAIT_D1;
          end
          default: state_d = IDLE;
        endcase
      end else if (rx_byte < 8'hF0) begin
        status_d = rx_byte[7:4];
        chan_d   = rx_byte[3:0];
        state_d  = WAIT_D1;
      end else if (rx_byte <= 8'hF7) begin
        state_d = IDLE;
      end else if (rx_byte == 8'hFF) begin
        state_d = IDLE;
        held_d  = 1'b0;
      end
      // 0xF8-0xFE real-time bytes fall through untouched.
    end

    if (msg_done && chan_ok) begin
      if (status_q == 4'h9 && msg_d2 != 7'd0) begin
        note_d = msg_d1;
        held_d = 1'b1;
        amp_d  = {msg_d2, msg_d2[6]};
      end else if (status_q == 4'h8 || status_q == 4'h9) begin
        if (held_q && msg_d1 == note_q) held_d = 1'b0;
      end
    end

    event_d = (note_d != note_q) || (held_d != held_q) || (amp_d != amp_q);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= 4'd0;
      chan_q   <= 4'd0;
      d1_q     <= 7'd0;
      note_q   <= 7'd0;
      held_q   <= 1'b0;
      amp_q    <= 8'd0;
      event_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      chan_q   <= chan_d;
      d1_q     <= d1_d;
      note_q   <= note_d;
      held_q   <= held_d;
      amp_q    <= amp_d;
      event_q  <= event_d;
      err_q    <= err_d;
    end
  end

  assign midi_data  = {1'b0, note_q};
  assign midi_valid = held_q;
  assign amplitude  = amp_q;
  assign note_event = event_q;
  assign parse_err  = err_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: expected outputs are queued per byte
// and compared one cycle after the byte is taken.
module tb_midi_note_parser;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic [7:0] amp;
    logic       ev;
    logic       err;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] midi_data;
  logic       midi_valid;
  logic [7:0] amplitude;
  logic       note_event;
  logic       parse_err;

  int   tests = 0;
  int   fails = 0;
  out_t exp_q[$];

  midi_note_parser #(.CHANNEL(0), .OMNI(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .midi_data  (midi_data),
    .midi_valid (midi_valid),
    .amplitude  (amplitude),
    .note_event (note_event),
    .parse_err  (parse_err)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [7:0] d, input logic v, input logic [7:0] a,
                              input logic ev, input logic er);
    out_t o;
    o.data = d; o.valid = v; o.amp = a; o.ev = ev; o.err = er;
    return o;
  endfunction

  task automatic compare(input string tag);
    out_t got;
    out_t want;
    got  = mk(midi_data, midi_valid, amplitude, note_event, parse_err);
    want = exp_q.pop_front();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed data=%h valid=%b amp=%h ev=%b err=%b, expected data=%h valid=%b amp=%h ev=%b err=%b",
             tag, got.data, got.valid, got.amp, got.ev, got.err,
             want.data, want.valid, want.amp, want.ev, want.err);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] b, input out_t e);
    exp_q.push_back(e);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    compare(tag);
  endtask

  task automatic idle(input string tag, input out_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Reset with a data byte presented at the same time; reset must win.
  task automatic do_reset();
    rst      = 1'b1;
    rx_byte  = 8'h3C;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    idle("reset_state", mk(8'h00, 0, 8'h00, 0, 0));

    // Basic note-on, running-status velocity-0 note-off.
    step("on_status", 8'h90, mk(8'h00, 0, 8'h00, 0, 0));
    step("on_d1",     8'h3C, mk(8'h00, 0, 8'h00, 0, 0));
    step("on_d2",     8'h7F, mk(8'h3C, 1, 8'hFF, 1, 0));
    idle("pulse_one_cycle",  mk(8'h3C, 1, 8'hFF, 0, 0));
    step("rs_off_d1", 8'h3C, mk(8'h3C, 1, 8'hFF, 0, 0));
    step("rs_off_d2", 8'h00, mk(8'h3C, 0, 8'hFF, 1, 0));

    // Last-note priority and note-off of a non-current note.
    step("n60_st",  8'h90, mk(8'h3C, 0, 8'hFF, 0, 0));
    step("n60_d1",  8'h3C, mk(8'h3C, 0, 8'hFF, 0, 0));
    step("n60_d2",  8'h40, mk(8'h3C, 1, 8'h81, 1, 0));
    step("n62_d1",  8'h3E, mk(8'h3C, 1, 8'h81, 0, 0));
    step("n62_d2",  8'h01, mk(8'h3E, 1, 8'h02, 1, 0));
    step("off60_st", 8'h80, mk(8'h3E, 1, 8'h02, 0, 0));
    step("off60_d1", 8'h3C, mk(8'h3E, 1, 8'h02, 0, 0));
    step("off60_d2", 8'h10, mk(8'h3E, 1, 8'h02, 0, 0));
    step("off62_d1", 8'h3E, mk(8'h3E, 1, 8'h02, 0, 0));
    step("off62_d2", 8'h10, mk(8'h3E, 0, 8'h02, 1, 0));

    // Real-time bytes interleaved inside a message.
    step("rt_st",  8'h90, mk(8'h3E, 0, 8'h02, 0, 0));
    step("rt_f8",  8'hF8, mk(8'h3E, 0, 8'h02, 0, 0));
    step("rt_d1",  8'h3C, mk(8'h3E, 0, 8'h02, 0, 0));
    step("rt_fe",  8'hFE, mk(8'h3E, 0, 8'h02, 0, 0));
    step("rt_d2",  8'h7F, mk(8'h3C, 1, 8'hFF, 1, 0));

    // Re-strike with identical note and velocity: no pulse.
    step("restrike_d1", 8'h3C, mk(8'h3C, 1, 8'hFF, 0, 0));
    step("restrike_d2", 8'h7F, mk(8'h3C, 1, 8'hFF, 0, 0));

    // Status byte aborts a partial message; the new status applies.
    step("abort_st",  8'h90, mk(8'h3C, 1, 8'hFF, 0, 0));
    step("abort_d1",  8'h3C, mk(8'h3C, 1, 8'hFF, 0, 0));
    step("abort_st2", 8'h90, mk(8'h3C, 1, 8'hFF, 0, 0));
    step("abort_n1",  8'h40, mk(8'h3C, 1, 8'hFF, 0, 0));
    step("abort_v",   8'h64, mk(8'h40, 1, 8'hC9, 1, 0));

    // Pitch bend is a complete two-byte message that is discarded.
    step("pb_st", 8'hE0, mk(8'h40, 1, 8'hC9, 0, 0));
    step("pb_d1", 8'h00, mk(8'h40, 1, 8'hC9, 0, 0));
    step("pb_d2", 8'h40, mk(8'h40, 1, 8'hC9, 0, 0));

    // After reset, a data byte has no running status.
    do_reset();
    idle("reset2_state", mk(8'h00, 0, 8'h00, 0, 0));
    step("err_no_rs",  8'h3C, mk(8'h00, 0, 8'h00, 0, 1));
    idle("err_one_cycle",     mk(8'h00, 0, 8'h00, 0, 0));
    step("pc_st",  8'hC0, mk(8'h00, 0, 8'h00, 0, 0));
    step("pc_d1",  8'h05, mk(8'h00, 0, 8'h00, 0, 0));
    step("pc_rs",  8'h3C, mk(8'h00, 0, 8'h00, 0, 0));
    step("ch1_st", 8'h91, mk(8'h00, 0, 8'h00, 0, 0));
    step("ch1_d1", 8'h3C, mk(8'h00, 0, 8'h00, 0, 0));
    step("ch1_d2", 8'h7F, mk(8'h00, 0, 8'h00, 0, 0));

    // Reset in the middle of a message.
    step("mid_st", 8'h90, mk(8'h00, 0, 8'h00, 0, 0));
    step("mid_d1", 8'h3C, mk(8'h00, 0, 8'h00, 0, 0));
    do_reset();
    step("mid_after_rst", 8'h7F, mk(8'h00, 0, 8'h00, 0, 1));

    // System Reset byte while a note is held.
    step("ff_st", 8'h90, mk(8'h00, 0, 8'h00, 0, 0));
    step("ff_d1", 8'h3C, mk(8'h00, 0, 8'h00, 0, 0));
    step("ff_d2", 8'h7F, mk(8'h3C, 1, 8'hFF, 1, 0));
    step("ff",    8'hFF, mk(8'h3C, 0, 8'hFF, 1, 0));
    step("ff_rs_cleared", 8'h3C, mk(8'h3C, 0, 8'hFF, 0, 1));

    // System common clears running status.
    step("sc_st", 8'h90, mk(8'h3C, 0, 8'hFF, 0, 0));
    step("sc_d1", 8'h40, mk(8'h3C, 0, 8'hFF, 0, 0));
    step("sc_f7", 8'hF7, mk(8'h3C, 0, 8'hFF, 0, 0));
    step("sc_data", 8'h64, mk(8'h3C, 0, 8'hFF, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
